instr_encoder: RTL

- Program-loader block: accepts one symbolic instruction per valid/ready handshake, packs it into the 32-bit MIPS word format that the Decode stage consumes, and writes it to instruction memory at sequential addresses.
- Sits between the testbench/host loader and the instruction memory write port.
- Terminates every program with the FINISH word (opcode 0x3F).

---
 rtl/mips_isa_pkg.sv | 26 ++
 rtl/instr_pack.sv | 55 +++++
 rtl/instr_encoder.sv | 80 ++++++++
 3 files changed

// File: rtl/mips_isa_pkg.sv
// mips_isa_pkg: encoder op enum, MIPS opcode/funct constants and word builders shared with Decode
package mips_isa_pkg;
  typedef enum logic [5:0] {
    OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_SLT,
    OP_SLL, OP_SRL, OP_SRA, OP_MUL, OP_JR,
    OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW,
    OP_BEQ, OP_BNE, OP_BGT, OP_BLT, OP_BLTE, OP_BLTU, OP_BGTU, OP_BGTE,
    OP_J, OP_JAL, OP_FINISH
  } in_op_t;
  localparam logic [5:0] OPC_RTYPE = 6'h00, OPC_J = 6'h02, OPC_JAL = 6'h03;
  localparam logic [5:0] OPC_BEQ = 6'h04, OPC_BNE = 6'h05, OPC_ADDI = 6'h08, OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_SLTI = 6'h0A, OPC_ANDI = 6'h0C, OPC_ORI = 6'h0D, OPC_XORI = 6'h0E;
  localparam logic [5:0] OPC_LUI = 6'h0F, OPC_LW = 6'h23, OPC_SW = 6'h2B;
  localparam logic [5:0] OPC_BGT = 6'h38, OPC_BLT = 6'h39, OPC_BLTE = 6'h3A, OPC_BLTU = 6'h3B;
  localparam logic [5:0] OPC_BGTU = 6'h3C, OPC_BGTE = 6'h3E, OPC_FINISH = 6'h3F;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_JR = 6'h08, FN_MUL = 6'h18;
  localparam logic [5:0] FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND = 6'h24, FN_OR = 6'h25, FN_XOR = 6'h26, FN_SLT = 6'h2A;
  localparam logic [31:0] FINISH_WORD = {OPC_FINISH, 26'd0};
  function automatic logic [31:0] r_word(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [4:0] sh, logic [5:0] fn);
    return {OPC_RTYPE, rs, rt, rd, sh, fn};
  endfunction
  function automatic logic [31:0] i_word(logic [5:0] opc, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction
endpackage

// File: rtl/instr_pack.sv
// instr_pack: combinational encoder op + fields -> 32-bit MIPS word and legality flag
module instr_pack
  import mips_isa_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] addr,
  output logic [31:0] word,
  output logic        legal
);
  always_comb begin
    word  = FINISH_WORD;
    legal = 1'b1;
    case (op)
      OP_ADD:    word = r_word(rs, rt, rd, 5'd0, FN_ADD);
      OP_ADDU:   word = r_word(rs, rt, rd, 5'd0, FN_ADDU);
      OP_SUB:    word = r_word(rs, rt, rd, 5'd0, FN_SUB);
      OP_SUBU:   word = r_word(rs, rt, rd, 5'd0, FN_SUBU);
      OP_AND:    word = r_word(rs, rt, rd, 5'd0, FN_AND);
      OP_OR:     word = r_word(rs, rt, rd, 5'd0, FN_OR);
      OP_XOR:    word = r_word(rs, rt, rd, 5'd0, FN_XOR);
      OP_SLT:    word = r_word(rs, rt, rd, 5'd0, FN_SLT);
      OP_SLL:    word = r_word(5'd0, rt, rd, shamt, FN_SLL);
      OP_SRL:    word = r_word(5'd0, rt, rd, shamt, FN_SRL);
      OP_SRA:    word = r_word(5'd0, rt, rd, shamt, FN_SRA);
      OP_MUL:    word = r_word(rs, rt, 5'd0, 5'd0, FN_MUL);
      OP_JR:     word = r_word(rs, 5'd0, 5'd0, 5'd0, FN_JR);
      OP_ADDI:   word = i_word(OPC_ADDI, rs, rt, imm);
      OP_ADDIU:  word = i_word(OPC_ADDIU, rs, rt, imm);
      OP_SLTI:   word = i_word(OPC_SLTI, rs, rt, imm);
      OP_ANDI:   word = i_word(OPC_ANDI, rs, rt, imm);
      OP_ORI:    word = i_word(OPC_ORI, rs, rt, imm);
      OP_XORI:   word = i_word(OPC_XORI, rs, rt, imm);
      OP_LUI:    word = i_word(OPC_LUI, 5'd0, rt, imm);
      OP_LW:     word = i_word(OPC_LW, rs, rt, imm);
      OP_SW:     word = i_word(OPC_SW, rs, rt, imm);
      OP_BEQ:    word = i_word(OPC_BEQ, rs, rt, imm);
      OP_BNE:    word = i_word(OPC_BNE, rs, rt, imm);
      OP_BGT:    word = i_word(OPC_BGT, rs, rt, imm);
      OP_BLT:    word = i_word(OPC_BLT, rs, rt, imm);
      OP_BLTE:   word = i_word(OPC_BLTE, rs, rt, imm);
      OP_BLTU:   word = i_word(OPC_BLTU, rs, rt, imm);
      OP_BGTU:   word = i_word(OPC_BGTU, rs, rt, imm);
      OP_BGTE:   word = i_word(OPC_BGTE, rs, rt, imm);
      OP_J:      word = {OPC_J, addr};
      OP_JAL:    word = {OPC_JAL, addr};
      OP_FINISH: word = FINISH_WORD;
      default:   legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: accepts symbolic instructions by handshake and writes packed words to imem,
// closing every program with FINISH (forced in the last slot on overflow)
module instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [5:0]    in_op,
  input  logic [4:0]    in_rs,
  input  logic [4:0]    in_rt,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_shamt,
  input  logic [15:0]   in_imm,
  input  logic [25:0]   in_addr,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   count,
  output logic          err_illegal,
  output logic          err_overflow
);
  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;
  state_t state, state_nx;
  logic [31:0] word, word_q;
  logic [AW-1:0] base;
  logic legal, fire, full, trunc, launch;
  instr_pack u_pack (
    .op(in_op), .rs(in_rs), .rt(in_rt), .rd(in_rd), .shamt(in_shamt),
    .imm(in_imm), .addr(in_addr), .word(word), .legal(legal)
  );
  assign in_ready   = state == ACCEPT;
  assign busy       = state == ACCEPT || state == WRITE;
  assign done       = state == DONE;
  assign imem_we    = state == WRITE;
  assign imem_addr  = imem_we ? base + count[AW-1:0] : '0;
  assign imem_wdata = imem_we ? word_q : '0;
  assign launch     = start && (state == IDLE || state == DONE);
  assign fire       = in_ready && in_valid && legal;
  assign full       = count == (AW+1)'(DEPTH - 1);
  // the last slot is held back for FINISH, so any other word arriving there is replaced
  assign trunc      = full && word != FINISH_WORD;
  always_comb begin
    state_nx = state;
    if (launch) state_nx = ACCEPT;
    else if (fire) state_nx = WRITE;
    else if (state == WRITE) state_nx = word_q == FINISH_WORD ? DONE : ACCEPT;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base         <= '0;
      count        <= '0;
      word_q       <= '0;
      err_illegal  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      if (launch) begin
        base         <= base_addr;
        count        <= '0;
        err_illegal  <= 1'b0;
        err_overflow <= 1'b0;
      end
      if (in_ready && in_valid && !legal) err_illegal <= 1'b1;
      if (fire) word_q <= trunc ? FINISH_WORD : word;
      if (fire && trunc) err_overflow <= 1'b1;
      if (imem_we) count <= count + 1'b1;
    end
  end
endmodule
